// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//   Generic pipeline stage register: one instruction word, a valid bit,
//   N_CH packed data channels and a control-bit vector. Each rising clock
//   edge performs exactly one action, highest priority first:
//     flush  -> capture a bubble (squash, wins even over hold)
//     hold / !en -> keep every register unchanged (replay)
//     stall  -> capture a bubble
//     else   -> load the incoming instruction
//   A bubble clears valid, injects NOP_INSTR, clears the KILL_MASK control
//   bits (others pass through) and still captures the data channels.
//
//   Optional feature: define PIPE_PERF_CNT_EN to build saturating 16-bit
//   bubble / hold performance counters. Without it the counter outputs are
//   tied to zero and no counter flops exist.
//
// Ports
//   clk        : clock, rising-edge active
//   rst        : asynchronous reset, active low
//   en         : stage load enable (0 holds every field)
//   stall      : hazard stall, capture a bubble
//   hold       : downstream stall, keep current contents
//   flush      : squash, capture a bubble
//   valid_in   : incoming instruction is real
//   instr_in   : incoming instruction word (16 bits)
//   data_in    : packed channels, channel k at [k*DATA_W +: DATA_W]
//   ctrl_in    : incoming control bits
//   valid_out  : registered valid
//   instr_out  : registered instruction
//   data_out   : registered data channels
//   ctrl_out   : registered control bits
//   bubble_out : current contents are an injected bubble
//   bubble_cnt : bubbles injected (counter build only, else 0)
//   hold_cnt   : cycles spent holding (counter build only, else 0)
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int                DATA_W    = 16,
  parameter int                N_CH      = 9,
  parameter int                CTRL_W    = 16,
  parameter logic [CTRL_W-1:0] KILL_MASK = {CTRL_W{1'b1}},
  parameter logic [15:0]       NOP_INSTR = 16'h0800
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     stall,
  input  logic                     hold,
  input  logic                     flush,
  input  logic                     valid_in,
  input  logic [15:0]              instr_in,
  input  logic [N_CH*DATA_W-1:0]   data_in,
  input  logic [CTRL_W-1:0]        ctrl_in,
  output logic                     valid_out,
  output logic [15:0]              instr_out,
  output logic [N_CH*DATA_W-1:0]   data_out,
  output logic [CTRL_W-1:0]        ctrl_out,
  output logic                     bubble_out,
  output logic [15:0]              bubble_cnt,
  output logic [15:0]              hold_cnt
);

  localparam int DW_TOT = N_CH * DATA_W;

  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_HOLD   = 2'd1,
    ACT_BUBBLE = 2'd2
  } act_e;

  act_e                act_s;

  logic                valid_r;
  logic [15:0]         instr_r;
  logic [DW_TOT-1:0]   data_r;
  logic [CTRL_W-1:0]   ctrl_r;
  logic                bubble_r;

  logic                valid_nxt_s;
  logic [15:0]         instr_nxt_s;
  logic [DW_TOT-1:0]   data_nxt_s;
  logic [CTRL_W-1:0]   ctrl_nxt_s;
  logic                bubble_nxt_s;

  // Action select: flush beats hold so a squashed instruction never replays.
  always_comb begin
    act_s = ACT_LOAD;
    if (flush) begin
      act_s = ACT_BUBBLE;
    end else if (hold || !en) begin
      act_s = ACT_HOLD;
    end else if (stall) begin
      act_s = ACT_BUBBLE;
    end else begin
      act_s = ACT_LOAD;
    end
  end

  // Next-state values for the stage register fields.
  always_comb begin
    valid_nxt_s  = valid_r;
    instr_nxt_s  = instr_r;
    data_nxt_s   = data_r;
    ctrl_nxt_s   = ctrl_r;
    bubble_nxt_s = bubble_r;
    case (act_s)
      ACT_BUBBLE: begin
        // Data still flows on a bubble; only valid/instr/killable ctrl are squashed.
        valid_nxt_s  = 1'b0;
        instr_nxt_s  = NOP_INSTR;
        data_nxt_s   = data_in;
        ctrl_nxt_s   = ctrl_in & ~KILL_MASK;
        bubble_nxt_s = 1'b1;
      end
      ACT_LOAD: begin
        valid_nxt_s  = valid_in;
        instr_nxt_s  = instr_in;
        data_nxt_s   = data_in;
        ctrl_nxt_s   = ctrl_in;
        bubble_nxt_s = 1'b0;
      end
      ACT_HOLD: begin
        valid_nxt_s  = valid_r;
        instr_nxt_s  = instr_r;
        data_nxt_s   = data_r;
        ctrl_nxt_s   = ctrl_r;
        bubble_nxt_s = bubble_r;
      end
      default: begin
        valid_nxt_s  = valid_r;
        instr_nxt_s  = instr_r;
        data_nxt_s   = data_r;
        ctrl_nxt_s   = ctrl_r;
        bubble_nxt_s = bubble_r;
      end
    endcase
  end

  // Stage register; reset presents a bubble carrying NOP_INSTR.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r  <= 1'b0;
      instr_r  <= NOP_INSTR;
      data_r   <= {DW_TOT{1'b0}};
      ctrl_r   <= {CTRL_W{1'b0}};
      bubble_r <= 1'b1;
    end else begin
      valid_r  <= valid_nxt_s;
      instr_r  <= instr_nxt_s;
      data_r   <= data_nxt_s;
      ctrl_r   <= ctrl_nxt_s;
      bubble_r <= bubble_nxt_s;
    end
  end

  assign valid_out  = valid_r;
  assign instr_out  = instr_r;
  assign data_out   = data_r;
  assign ctrl_out   = ctrl_r;
  assign bubble_out = bubble_r;

`ifdef PIPE_PERF_CNT_EN
  logic [15:0] bubble_cnt_r;
  logic [15:0] hold_cnt_r;

  // Saturating performance counters; they stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt_r <= 16'd0;
      hold_cnt_r   <= 16'd0;
    end else begin
      if ((act_s == ACT_BUBBLE) && (bubble_cnt_r != 16'hFFFF)) begin
        bubble_cnt_r <= bubble_cnt_r + 16'd1;
      end else begin
        bubble_cnt_r <= bubble_cnt_r;
      end
      if ((act_s == ACT_HOLD) && (hold_cnt_r != 16'hFFFF)) begin
        hold_cnt_r <= hold_cnt_r + 16'd1;
      end else begin
        hold_cnt_r <= hold_cnt_r;
      end
    end
  end

  assign bubble_cnt = bubble_cnt_r;
  assign hold_cnt   = hold_cnt_r;
`else
  assign bubble_cnt = 16'd0;
  assign hold_cnt   = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//   Directed bench for pipe_stage_reg (N_CH=9, KILL_MASK=16'h001F) plus a
//   narrow N_CH=1 copy fed with channel 0. A behavioural model of the stage
//   contents is advanced at every rising edge from the current inputs, and a
//   compare process checks both DUTs against it on every falling edge.
//   Literal expectations pin the model at the interesting points.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

  localparam int          DW  = 16;
  localparam int          NCH = 9;
  localparam int          CW  = 16;
  localparam logic [15:0] KM  = 16'h001F;
  localparam logic [15:0] NOP = 16'h0800;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, en, stall, hold, flush, valid_in;
  logic [15:0]        instr_in;
  logic [NCH*DW-1:0]  data_in;
  logic [CW-1:0]      ctrl_in;

  logic               valid_out, bubble_out;
  logic [15:0]        instr_out, bubble_cnt, hold_cnt;
  logic [NCH*DW-1:0]  data_out;
  logic [CW-1:0]      ctrl_out;

  logic               n_valid_out, n_bubble_out;
  logic [15:0]        n_instr_out, n_bubble_cnt, n_hold_cnt;
  logic [DW-1:0]      n_data_out;
  logic [CW-1:0]      n_ctrl_out;

  pipe_stage_reg #(.DATA_W(DW), .N_CH(NCH), .CTRL_W(CW), .KILL_MASK(KM), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .en(en), .stall(stall), .hold(hold), .flush(flush),
    .valid_in(valid_in), .instr_in(instr_in), .data_in(data_in), .ctrl_in(ctrl_in),
    .valid_out(valid_out), .instr_out(instr_out), .data_out(data_out), .ctrl_out(ctrl_out),
    .bubble_out(bubble_out), .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt)
  );

  pipe_stage_reg #(.DATA_W(DW), .N_CH(1), .CTRL_W(CW), .KILL_MASK(KM), .NOP_INSTR(NOP)) dut_n1 (
    .clk(clk), .rst(rst), .en(en), .stall(stall), .hold(hold), .flush(flush),
    .valid_in(valid_in), .instr_in(instr_in), .data_in(data_in[DW-1:0]), .ctrl_in(ctrl_in),
    .valid_out(n_valid_out), .instr_out(n_instr_out), .data_out(n_data_out), .ctrl_out(n_ctrl_out),
    .bubble_out(n_bubble_out), .bubble_cnt(n_bubble_cnt), .hold_cnt(n_hold_cnt)
  );

  // Behavioural model of what the stage must hold.
  logic               m_valid, m_bubble;
  logic [15:0]        m_instr, m_bcnt, m_hcnt;
  logic [NCH*DW-1:0]  m_data;
  logic [CW-1:0]      m_ctrl;

  int checks   = 0;
  int failures = 0;
  bit perf_on;

  task automatic chk(input string nm, input logic [NCH*DW-1:0] act, input logic [NCH*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_instr = NOP; m_data = '0; m_ctrl = '0; m_bubble = 1'b1;
    m_bcnt = 16'd0; m_hcnt = 16'd0;
  endtask

  // Rules of one rising edge, applied to the inputs present at that edge.
  task automatic model_edge();
    if (!rst) begin
      model_reset();
    end else if (flush || (en && !hold && stall)) begin
      m_valid = 1'b0; m_instr = NOP; m_data = data_in;
      m_ctrl = ctrl_in & ~KM; m_bubble = 1'b1;
      if (perf_on && m_bcnt < 16'hFFFF) m_bcnt = m_bcnt + 16'd1;
    end else if (hold || !en) begin
      if (perf_on && m_hcnt < 16'hFFFF) m_hcnt = m_hcnt + 16'd1;
    end else begin
      m_valid = valid_in; m_instr = instr_in; m_data = data_in;
      m_ctrl = ctrl_in; m_bubble = 1'b0;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Continuous compare of both DUTs against the model.
  always @(negedge clk) begin
    chk("valid",   valid_out,  m_valid);
    chk("instr",   instr_out,  m_instr);
    chk("data",    data_out,   m_data);
    chk("ctrl",    ctrl_out,   m_ctrl);
    chk("bubble",  bubble_out, m_bubble);
    chk("bcnt",    bubble_cnt, m_bcnt);
    chk("hcnt",    hold_cnt,   m_hcnt);
    chk("n1_valid", n_valid_out,  m_valid);
    chk("n1_instr", n_instr_out,  m_instr);
    chk("n1_data",  n_data_out,   m_data[DW-1:0]);
    chk("n1_ctrl",  n_ctrl_out,   m_ctrl);
    chk("n1_bubble",n_bubble_out, m_bubble);
    chk("n1_bcnt",  n_bubble_cnt, m_bcnt);
    chk("n1_hcnt",  n_hold_cnt,   m_hcnt);
  end

  initial begin
`ifdef PIPE_PERF_CNT_EN
    perf_on = 1'b1;
`else
    perf_on = 1'b0;
`endif
    rst = 1'b0; en = 1'b1; stall = 1'b0; hold = 1'b0; flush = 1'b0;
    valid_in = 1'b0; instr_in = 16'h1234; data_in = '1; ctrl_in = 16'hFFFF;
    model_reset();
    cyc(); cyc();
    rst = 1'b1;

    // Reset state
    chk("rst_valid",  valid_out,  1'b0);
    chk("rst_instr",  instr_out,  16'h0800);
    chk("rst_data",   data_out,   '0);
    chk("rst_ctrl",   ctrl_out,   16'h0000);
    chk("rst_bubble", bubble_out, 1'b1);
    chk("rst_bcnt",   bubble_cnt, 16'h0000);

    // Plain load
    valid_in = 1'b1; instr_in = 16'h4123; ctrl_in = 16'hFFFF;
    data_in = '0;
    for (int k = 0; k < NCH; k++) data_in[k*DW +: DW] = 16'h1000 * k[15:0] + 16'h0040;
    cyc();
    chk("ld_instr",  instr_out,       16'h4123);
    chk("ld_valid",  valid_out,       1'b1);
    chk("ld_ch0",    data_out[15:0],  16'h0040);
    chk("ld_ch8",    data_out[143:128], 16'h8040);
    chk("ld_ctrl",   ctrl_out,        16'hFFFF);
    chk("ld_bubble", bubble_out,      1'b0);

    // Stall: bubble, only low 5 ctrl bits killed
    stall = 1'b1; instr_in = 16'hA5A5; ctrl_in = 16'hFFFF;
    cyc();
    chk("st_instr",  instr_out,  16'h0800);
    chk("st_ctrl",   ctrl_out,   16'hFFE0);
    chk("st_valid",  valid_out,  1'b0);
    chk("st_bubble", bubble_out, 1'b1);
    stall = 1'b0;

    // Load then hold three cycles with changing inputs
    instr_in = 16'h4123; ctrl_in = 16'h3C3C; data_in[15:0] = 16'h0077;
    cyc();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      instr_in = 16'h5000 + i[15:0]; ctrl_in = ~ctrl_in; data_in = ~data_in;
      valid_in = ~valid_in; stall = i[0];
      cyc();
      chk("hold_instr", instr_out, 16'h4123);
    end
    chk("hold_ctrl", ctrl_out, 16'h3C3C);
    if (perf_on) chk("hold_cnt3", hold_cnt, 16'd3);
    else         chk("hold_cnt0", hold_cnt, 16'd0);
    stall = 1'b0;

    // Flush with hold: flush wins
    flush = 1'b1; ctrl_in = 16'hABCD;
    cyc();
    chk("fh_instr", instr_out, 16'h0800);
    chk("fh_valid", valid_out, 1'b0);
    chk("fh_ctrl",  ctrl_out,  16'hABC0);
    if (perf_on) begin
      chk("fh_bcnt", bubble_cnt, 16'd2);
      chk("fh_hcnt", hold_cnt,   16'd3);
    end
    flush = 1'b0; hold = 1'b0;

    // en=0 holds even with stall; en=0 with flush still flushes
    valid_in = 1'b1; instr_in = 16'h7777; ctrl_in = 16'h0F0F; data_in = {NCH{16'hBEEF}};
    cyc();
    en = 1'b0; stall = 1'b1; instr_in = 16'h6666; cyc();
    chk("en0_instr", instr_out, 16'h7777);
    stall = 1'b0; cyc();
    flush = 1'b1; cyc();
    chk("en0_flush", instr_out, 16'h0800);
    flush = 1'b0; en = 1'b1;
    valid_in = 1'b0; instr_in = 16'h2222; cyc();
    chk("inv_load_bubble", bubble_out, 1'b0);

    // Async reset while holding valid data
    valid_in = 1'b1; instr_in = 16'h4123; ctrl_in = 16'hFFFF; data_in = {NCH{16'h1357}};
    cyc();
    hold = 1'b1; cyc();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk("arst_valid",  valid_out,  1'b0);
    chk("arst_instr",  instr_out,  16'h0800);
    chk("arst_data",   data_out,   '0);
    chk("arst_ctrl",   ctrl_out,   16'h0000);
    chk("arst_bubble", bubble_out, 1'b1);
    chk("arst_hcnt",   hold_cnt,   16'h0000);
    cyc();
    rst = 1'b1;
    cyc();
    chk("post_rst_hold", instr_out, 16'h0800);
    hold = 1'b0;

    // Long stall run: counter saturates
    stall = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      instr_in = i[15:0]; data_in[15:0] = i[15:0];
      cyc();
    end
    if (perf_on) chk("sat_bcnt", bubble_cnt, 16'hFFFF);
    else         chk("off_bcnt", bubble_cnt, 16'h0000);
    cyc(); cyc();
    if (perf_on) chk("sat_stay", bubble_cnt, 16'hFFFF);
    else         chk("off_stay", bubble_cnt, 16'h0000);
    stall = 1'b0;
    cyc();

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
